// File: rtl/stream_pkg.sv
// Shared helpers for the stream lane serializer: counter widths and valid-prefix counting.
package stream_pkg;

    // Upper bound on lane count accepted by prefix_count.
    localparam int unsigned MaxLanes = 32;

    function automatic int unsigned cnt_w(input int unsigned lanes);
        return $clog2(lanes + 1);
    endfunction

    function automatic int unsigned idx_w(input int unsigned lanes);
        return $clog2(lanes + 1);
    endfunction

    // Number of consecutive ones starting at bit 0.
    function automatic int unsigned prefix_count(input logic [MaxLanes-1:0] vld);
        int unsigned n;
        logic        run;
        n   = 0;
        run = 1'b1;
        for (int i = 0; i < MaxLanes; i++) begin
            run = run & vld[i];
            if (run) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/stream_lane_buf.sv
// Per-lane enable-written payload registers with a read mux selected by lane index.
module stream_lane_buf #(
    parameter int unsigned Depth     = 2,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdxW      = 2
) (
    input  logic                       clk,
    input  logic [Depth-1:0]           wr_en,
    input  logic [Depth*DataWidth-1:0] wr_data,
    input  logic [IdxW-1:0]            rd_idx,
    output logic [DataWidth-1:0]       rd_data
);

    logic [DataWidth-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        for (int i = 0; i < Depth; i++) begin
            if (wr_en[i]) mem[i] <= wr_data[i*DataWidth +: DataWidth];
        end
    end

    // Out-of-range indices (possible once a bundle is fully drained) read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < Depth; i++) begin
            if (rd_idx == IdxW'(i)) rd_data = mem[i];
        end
    end

endmodule

// File: rtl/stream_lane_serializer.sv
// Serializes an InWidth-lane in-order bundle onto a single valid/ready stream, lane 0 first.
// Optional 0-cycle bypass from lane 0 when idle: define STREAM_LANE_SERIALIZER_BYPASS_EN.
module stream_lane_serializer
    import stream_pkg::*;
#(
    parameter int unsigned InWidth   = 2,
    parameter int unsigned DataWidth = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [InWidth-1:0]           in_vld_i,
    input  logic [InWidth*DataWidth-1:0] in_payload_i,
    output logic [InWidth-1:0]           in_rdy_o,
    output logic                         out_vld_o,
    output logic [DataWidth-1:0]         out_payload_o,
    input  logic                         out_rdy_i,
    input  logic                         flush_i
);

    localparam int unsigned CntW = cnt_w(InWidth);
    localparam int unsigned IdxW = idx_w(InWidth);

    logic [CntW-1:0]              cnt_q, cnt_d, n;
    logic [IdxW-1:0]              rd_idx_q, rd_idx_d;
    logic                         win, capture, out_fire;
    logic [InWidth-1:0]           fired, wr_en;
    logic [InWidth*DataWidth-1:0] wr_data;
    logic [DataWidth-1:0]         rd_data;

    // A new bundle may enter when empty or when the last item leaves this cycle.
    assign win      = ~flush_i & ((cnt_q == '0) | ((cnt_q == CntW'(1)) & out_rdy_i));
    assign in_rdy_o = {InWidth{win}};
    assign fired    = in_vld_i & in_rdy_o;
    assign n        = CntW'(prefix_count(MaxLanes'(fired)));
    assign capture  = win & (n != '0);

`ifdef STREAM_LANE_SERIALIZER_BYPASS_EN
    logic bypass;
    assign bypass        = (cnt_q == '0) & ~flush_i & in_vld_i[0];
    assign out_vld_o     = bypass | ((cnt_q != '0) & ~flush_i);
    assign out_payload_o = bypass ? in_payload_i[DataWidth-1:0] : rd_data;
`else
    assign out_vld_o     = (cnt_q != '0) & ~flush_i;
    assign out_payload_o = rd_data;
`endif
    assign out_fire = out_vld_o & out_rdy_i;

    always_comb begin
        cnt_d    = cnt_q;
        rd_idx_d = rd_idx_q;
        wr_en    = '0;
        wr_data  = in_payload_i;
        if (flush_i) begin
            cnt_d    = '0;
            rd_idx_d = '0;
        end else if (capture) begin
            rd_idx_d = '0;
`ifdef STREAM_LANE_SERIALIZER_BYPASS_EN
            // Lane 0 leaves through the bypass; store only the remaining lanes, shifted down.
            if (bypass && out_rdy_i) begin
                cnt_d = n - CntW'(1);
                for (int i = 0; i < InWidth - 1; i++) begin
                    wr_en[i] = (i + 1) < int'(n);
                    wr_data[i*DataWidth +: DataWidth] = in_payload_i[(i+1)*DataWidth +: DataWidth];
                end
            end else
`endif
            begin
                cnt_d = n;
                for (int i = 0; i < InWidth; i++) begin
                    wr_en[i] = i < int'(n);
                end
            end
        end else if (out_fire) begin
            cnt_d    = cnt_q - CntW'(1);
            rd_idx_d = rd_idx_q + IdxW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            rd_idx_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            rd_idx_q <= rd_idx_d;
        end
    end

    stream_lane_buf #(
        .Depth     (InWidth),
        .DataWidth (DataWidth),
        .IdxW      (IdxW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_idx  (rd_idx_q),
        .rd_data (rd_data)
    );

    logic [InWidth-1:0] vld_lower;
    assign vld_lower = {in_vld_i[InWidth-2:0], 1'b1};

    prefix_vld_a: assert property (@(posedge clk) disable iff (rst)
        (in_vld_i & ~vld_lower) == '0);

endmodule
